spi_frame_rx: RTL and testbench

Receive side of the team's three-phase serial byte link. Decodes the stream produced by the link transmitter into parallel bytes: active-low frame enable, and every data bit sent as a three-cycle group (marker 1, data bit, guard 0), 8 bits LSB first. Delivers each byte on a valid/ready output register and flags framing and overrun errors. Sits between the link pins and the decryption/hash datapath.

---
 rtl/spi_link_pkg.sv | 23 ++
 rtl/spi_line_sync.sv | 53 +++++
 rtl/spi_frame_rx.sv | 154 +++++++++++++++
 tb/tb_spi_frame_rx.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_link_pkg.sv
// spi_link_pkg
//   Shared definitions for the three-phase serial byte link. The transmitter and
//   receiver both use these so the framing constants stay in one place.
//   A data bit travels as a group of GROUP_LEN cycles: marker (1), data, guard (0).
//   Bytes are BITS_PER_BYTE groups, LSB first.
package spi_link_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int GROUP_LEN     = 3;

    // Bit counter is wide enough to hold BITS_PER_BYTE itself (the value seen
    // in the guard phase of the last bit).
    localparam int CNT_W = 4;

    // Receiver FSM encoding; exported as-is on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_MARK = 2'd1,
        ST_DATA      = 2'd2,
        ST_GUARD     = 2'd3
    } rx_state_e;

endpackage

// File: rtl/spi_line_sync.sv
// spi_line_sync
//   N-flop synchronizer for the serial link pins. With N = 0 the pins pass
//   straight through (transmitter running on the same clock).
//   Reset values are the idle line: enable deasserted (1), data 0.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   spi_in    raw serial data pin
//   spi_en_n  raw active-low frame enable pin
//   s_in      synchronized data
//   s_en_n    synchronized enable
module spi_line_sync #(
    parameter int N = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_in,
    input  logic spi_en_n,
    output logic s_in,
    output logic s_en_n
);

    generate
        if (N == 0) begin : g_pass
            // Clock and reset have no job in pass-through mode.
            logic unused_pass;
            assign unused_pass = clk ^ rst;
            assign s_in        = spi_in;
            assign s_en_n      = spi_en_n;
        end else begin : g_sync
            logic [N-1:0] in_q;
            logic [N-1:0] en_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    in_q <= '0;
                    en_q <= '1;
                end else begin
                    in_q[0] <= spi_in;
                    en_q[0] <= spi_en_n;
                    for (int i = 1; i < N; i++) begin
                        in_q[i] <= in_q[i-1];
                        en_q[i] <= en_q[i-1];
                    end
                end
            end

            assign s_in   = in_q[N-1];
            assign s_en_n = en_q[N-1];
        end
    endgenerate

endmodule

// File: rtl/spi_frame_rx.sv
// spi_frame_rx
//   Receive side of the three-phase serial byte link. Each bit arrives as a
//   three-cycle group (marker 1, data, guard 0), eight bits LSB first, while the
//   active-low frame enable is held low. Completed bytes are presented on a
//   valid/ready output register; framing violations and dropped bytes raise
//   one-cycle pulses.
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   spi_in      serial data line
//   spi_en_n    active-low frame enable
//   data_out    received byte
//   data_valid  data_out holds an unconsumed byte
//   data_ready  consumer accepts data_out
//   busy        a byte is being received (bit count non-zero or mid-group)
//   frame_err   one-cycle pulse on a framing violation
//   overrun     one-cycle pulse when a completed byte had to be dropped
//   state_dbg   current receiver FSM state (rx_state_e encoding)
//
// Output handshake: a byte transfers on every rising edge where data_valid and
// data_ready are both 1. data_valid rises on the edge a byte completes and
// stays up, with data_out stable, until that transfer. data_ready is ignored
// while data_valid is 0. A byte completing on the same edge as a transfer
// replaces the outgoing one without a bubble; a byte completing while the
// previous one is still held and not being taken is dropped (overrun).
module spi_frame_rx
    import spi_link_pkg::*;
#(
    parameter int SYNC_STAGES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_in,
    input  logic       spi_en_n,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic [1:0] state_dbg
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS_PER_BYTE);

    logic             s_in;
    logic             s_en_n;
    rx_state_e        state;
    logic [CNT_W-1:0] bit_cnt;
    logic [7:0]       shift_reg;

    spi_line_sync #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .spi_in   (spi_in),
        .spi_en_n (spi_en_n),
        .s_in     (s_in),
        .s_en_n   (s_en_n)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // Consumer takes the held byte; a byte loaded below on this same
            // edge overrides this clear.
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!s_en_n) begin
                        state   <= ST_WAIT_MARK;
                        bit_cnt <= '0;
                    end
                end

                ST_WAIT_MARK: begin
                    if (s_en_n) begin
                        // Frame closed; only an error if it cut a byte short.
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                    end else if (s_in) begin
                        state <= ST_DATA;
                    end else if (bit_cnt != '0) begin
                        // A missing marker inside a byte loses bit alignment.
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                    end
                end

                ST_DATA: begin
                    if (s_en_n) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        // LSB first: each new bit enters at the top and walks down.
                        shift_reg <= {s_in, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        state     <= ST_GUARD;
                    end
                end

                ST_GUARD: begin
                    if (s_en_n) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= ST_IDLE;
                    end else if (s_in) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= ST_WAIT_MARK;
                    end else begin
                        state <= ST_WAIT_MARK;
                        if (bit_cnt == CNT_FULL) begin
                            bit_cnt <= '0;
                            if (!data_valid || data_ready) begin
                                data_out   <= shift_reg;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

    assign busy      = (bit_cnt != '0) || (state == ST_DATA) || (state == ST_GUARD);
    assign state_dbg = state;

endmodule

// File: tb/tb_spi_frame_rx.sv
module tb_spi_frame_rx;
    import spi_link_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_in;
    logic       spi_en_n;
    logic       data_ready;

    logic [7:0] data_out,  data_out2;
    logic       data_valid, data_valid2;
    logic       busy, busy2;
    logic       frame_err, frame_err2;
    logic       overrun, overrun2;
    logic [1:0] state_dbg, state_dbg2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int rise0 = -1;
    int rise2 = -1;
    logic dv0_q = 1'b0;
    logic dv2_q = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    typedef struct {
        logic [7:0] tx;
        int         gap;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    spi_frame_rx #(.SYNC_STAGES(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .spi_in     (spi_in),
        .spi_en_n   (spi_en_n),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .state_dbg  (state_dbg)
    );

    spi_frame_rx #(.SYNC_STAGES(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .spi_in     (spi_in),
        .spi_en_n   (spi_en_n),
        .data_out   (data_out2),
        .data_valid (data_valid2),
        .data_ready (data_ready),
        .busy       (busy2),
        .frame_err  (frame_err2),
        .overrun    (overrun2),
        .state_dbg  (state_dbg2)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err || overrun) begin
                total++;
                if (frame_err && overrun) begin
                    bad++;
                    $display("FAIL err_overlap: frame_err=%0b overrun=%0b, required not both", frame_err, overrun);
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (data_valid && data_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL accept: got 0x%02h, required no byte", data_out);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (data_out !== exp_b) begin
                        bad++;
                        $display("FAIL accept: got 0x%02h, required 0x%02h", data_out, exp_b);
                    end
                end
            end
        end
        if (data_valid && !dv0_q)  rise0 = cyc;
        if (data_valid2 && !dv2_q) rise2 = cyc;
        dv0_q = data_valid;
        dv2_q = data_valid2;
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Present one line cycle; returns just after the edge that sampled it.
    task automatic drive(input logic in_v, input logic en_v);
        spi_in   = in_v;
        spi_en_n = en_v;
        @(posedge clk);
        #1;
    endtask

    task automatic send_group(input logic b);
        drive(1'b1, 1'b0);
        drive(b,    1'b0);
        drive(1'b0, 1'b0);
    endtask

    // Sends a full byte. With chk set, verifies data_valid is still low before
    // the final guard and that the byte is presented right after it.
    task automatic send_byte(input logic [7:0] b, input logic chk,
                             input logic [7:0] exp_d, input string nm);
        for (int i = 0; i < BITS_PER_BYTE; i++) begin
            drive(1'b1, 1'b0);
            drive(b[i], 1'b0);
            if (chk && i == BITS_PER_BYTE - 1)
                check({nm, "_valid_early"}, {31'd0, data_valid}, 32'd0);
            drive(1'b0, 1'b0);
        end
        if (chk) begin
            check({nm, "_valid"}, {31'd0, data_valid}, 32'd1);
            check({nm, "_data"},  {24'd0, data_out},   {24'd0, exp_d});
        end
    endtask

    task automatic start_frame();
        drive(1'b0, 1'b0);
    endtask

    task automatic end_frame();
        repeat (4) drive(1'b0, 1'b1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- test ----------------
    initial begin
        int fe0, ov0, start_c;
        bit a5_line[24];

        vecs[0] = '{tx: 8'h00, gap: 1, exp_data: 8'h00};
        vecs[1] = '{tx: 8'hFF, gap: 0, exp_data: 8'hFF};
        vecs[2] = '{tx: 8'h3C, gap: 2, exp_data: 8'h3C};
        vecs[3] = '{tx: 8'h81, gap: 0, exp_data: 8'h81};
        vecs[4] = '{tx: 8'h5A, gap: 1, exp_data: 8'h5A};
        vecs[5] = '{tx: 8'h01, gap: 3, exp_data: 8'h01};

        // 0xA5 on the line, group by group.
        a5_line = '{1,1,0, 1,0,0, 1,1,0, 1,0,0, 1,0,0, 1,1,0, 1,0,0, 1,1,0};

        rst        = 1'b0;
        spi_in     = 1'b0;
        spi_en_n   = 1'b1;
        data_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        check("rst_data_out",   {24'd0, data_out},   32'h00);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_frame_err",  {31'd0, frame_err},  32'd0);
        check("rst_overrun",    {31'd0, overrun},    32'd0);
        check("rst_state",      {30'd0, state_dbg},  {30'd0, ST_IDLE});

        rst = 1'b1;
        drive(1'b0, 1'b1);

        // ---- 0xA5 from an explicit line pattern ----
        data_ready = 1'b1;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        exp_q.push_back(8'hA5);
        start_frame();
        for (int i = 0; i < BITS_PER_BYTE * GROUP_LEN; i++) begin
            drive(a5_line[i], 1'b0);
            if (i == BITS_PER_BYTE * GROUP_LEN - 2)
                check("a5_valid_early", {31'd0, data_valid}, 32'd0);
        end
        check("a5_valid", {31'd0, data_valid}, 32'd1);
        check("a5_data",  {24'd0, data_out},   32'hA5);
        drive(1'b0, 1'b0);
        check("a5_consumed", {31'd0, data_valid}, 32'd0);
        end_frame();
        check("a5_frame_err", fe_cnt - fe0, 32'd0);
        check("a5_overrun",   ov_cnt - ov0, 32'd0);

        // ---- table: several bytes in one frame, varying gaps ----
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        start_frame();
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(vecs[v].exp_data);
            repeat (vecs[v].gap) drive(1'b0, 1'b0);
            send_byte(vecs[v].tx, 1'b1, vecs[v].exp_data, $sformatf("vec%0d", v));
        end
        drive(1'b0, 1'b0);
        end_frame();
        check("vec_frame_err", fe_cnt - fe0, 32'd0);
        check("vec_overrun",   ov_cnt - ov0, 32'd0);

        // ---- overrun: 0x3C held while 0xFF completes ----
        data_ready = 1'b0;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        exp_q.push_back(8'h3C);
        start_frame();
        send_byte(8'h3C, 1'b1, 8'h3C, "ovr_first");
        drive(1'b0, 1'b0);
        send_byte(8'hFF, 1'b0, 8'h00, "ovr_second");
        check("ovr_pulse",     {31'd0, overrun},    32'd1);
        check("ovr_no_ferr",   {31'd0, frame_err},  32'd0);
        check("ovr_data_held", {24'd0, data_out},   32'h3C);
        check("ovr_valid",     {31'd0, data_valid}, 32'd1);
        data_ready = 1'b1;
        drive(1'b0, 1'b0);
        check("ovr_consumed", {31'd0, data_valid}, 32'd0);
        end_frame();
        check("ovr_count",      ov_cnt - ov0, 32'd1);
        check("ovr_ferr_count", fe_cnt - fe0, 32'd0);

        // ---- bad guard during bit 4 of 0x00; the sender abandons that byte ----
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        start_frame();
        for (int i = 0; i < 4; i++) send_group(1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        check("guard_ferr", {31'd0, frame_err}, 32'd1);
        check("guard_busy", {31'd0, busy},      32'd0);
        check("guard_no_valid", {31'd0, data_valid}, 32'd0);
        repeat (3) drive(1'b0, 1'b0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1, 8'h81, "guard_next");
        drive(1'b0, 1'b0);
        end_frame();
        check("guard_ferr_count", fe_cnt - fe0, 32'd1);
        check("guard_ovr_count",  ov_cnt - ov0, 32'd0);

        // ---- enable raised after bit 5 ----
        fe0 = fe_cnt;
        start_frame();
        for (int i = 0; i < 6; i++) send_group(1'b1);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        drive(1'b0, 1'b1);
        check("abort_ferr",  {31'd0, frame_err}, 32'd1);
        check("abort_busy",  {31'd0, busy},      32'd0);
        check("abort_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        repeat (3) drive(1'b0, 1'b1);
        exp_q.push_back(8'h5A);
        start_frame();
        send_byte(8'h5A, 1'b1, 8'h5A, "abort_next");
        drive(1'b0, 1'b0);
        end_frame();
        check("abort_ferr_count", fe_cnt - fe0, 32'd1);

        // ---- reset during bit 3, with a byte still held ----
        data_ready = 1'b0;
        start_frame();
        send_byte(8'h77, 1'b0, 8'h00, "rst_held");
        drive(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_group(1'b1);
        drive(1'b1, 1'b0);
        spi_in = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid",    {31'd0, data_valid}, 32'd0);
        check("midrst_data_out", {24'd0, data_out},   32'h00);
        check("midrst_busy",     {31'd0, busy},       32'd0);
        check("midrst_state",    {30'd0, state_dbg},  {30'd0, ST_IDLE});
        @(posedge clk);
        #1;
        check("midrst_ferr", {31'd0, frame_err}, 32'd0);
        check("midrst_ovr",  {31'd0, overrun},   32'd0);
        spi_in   = 1'b0;
        spi_en_n = 1'b1;
        rst      = 1'b1;
        data_ready = 1'b1;
        drive(1'b0, 1'b1);
        exp_q.push_back(8'h01);
        start_frame();
        send_byte(8'h01, 1'b1, 8'h01, "after_rst");
        drive(1'b0, 1'b0);
        end_frame();

        // ---- 0xC3 through both synchronizer depths ----
        start_c = cyc;
        exp_q.push_back(8'hC3);
        start_frame();
        send_byte(8'hC3, 1'b1, 8'hC3, "sync0");
        repeat (4) drive(1'b0, 1'b0);
        check("sync2_data",  {24'd0, data_out2}, 32'hC3);
        check("sync0_fresh", {31'd0, rise0 > start_c}, 32'd1);
        check("sync2_delay", rise2 - rise0, 32'd2);
        end_frame();

        check("exp_q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
